pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Central pipeline sequencer for the 5-stage MIPS core.
- Per cycle it generates an enable and a flush for each pipeline register: pc, if_id, id_ex, ex_mem, mem_wb.
- Sources: stall requests from the IF/ID/EX/MEM stages and the exception/ERET report from the MEM stage.
- Redirects the PC to the exception vector or EPC. When an instruction fetch is in flight, it holds the redirect until the fetch drains.

Parameters:
- EXC_VECTOR, 32'hBFC00380, general exception handler address.
- RESET_PC, 32'hBFC00000, value of redirect_pc while in reset.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- stallreq_if  in  1  IF waiting on instruction bus (fetch in flight).
- stallreq_id  in  1  ID load-use hazard.
- stallreq_ex  in  1  EX multi-cycle op (div/madd) busy.
- stallreq_mem  in  1  MEM waiting on data bus.
- mem_except_valid  in  1  MEM-stage instruction takes an exception (not ERET).
- mem_eret  in  1  MEM-stage instruction is ERET.
- cp0_epc  in  32  current EPC.
- en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb  out  1 each  register enables.
- flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb  out  1 each  bubble inserts. Flush wins over enable inside the register.
- redirect_valid  out  1  load pc from redirect_pc this cycle.
- redirect_pc  out  32  redirect target.
- busy_drain  out  1  high while in DRAIN.

Behaviour:
- Outputs are combinational from state plus inputs; state updates on posedge clk.
- States: RUN, DRAIN. Registers: state, pending_pc[31:0].
- Reset (rst=1):
  - state<=RUN, pending_pc<=0.
  - Outputs during rst: all en_*=0, all flush_*=1, redirect_valid=0, redirect_pc=RESET_PC, busy_drain=0.
- RUN, no exception: find the deepest stalled stage k (MEM=3 > EX=2 > ID=1 > IF=0).
  - Registers feeding stages 0..k hold (en=0).
  - The register after stage k gets flush=1.
  - All later registers have en=1 and flush=0.
  - Stall by stage:
    - MEM: hold pc..ex_mem, flush mem_wb.
    - EX: hold pc..id_ex, flush ex_mem.
    - ID: hold pc, if_id; flush id_ex.
    - IF: hold pc, flush if_id.
  - No stall: all en=1, all flush=0.
- RUN, exception (mem_except_valid or mem_eret):
  - Priority over every stallreq (MEM guarantees no bus request for a faulting instruction).
  - Target: mem_eret ? cp0_epc : EXC_VECTOR. If both are set, mem_except_valid wins and the target is EXC_VECTOR.
  - flush_if_id=flush_id_ex=flush_ex_mem=1.
  - en_mem_wb=1, flush_mem_wb=0, so WB commits the CP0 effect.
  - If stallreq_if=0: redirect_valid=1, redirect_pc=target, en_pc=1, stay RUN.
  - If stallreq_if=1: redirect_valid=0, en_pc=0, pending_pc<=target, go DRAIN.
- DRAIN:
  - busy_drain=1, en_pc=0.
  - All four flush_* = 1 every cycle; the other en_* are don't-care (flush wins).
  - Exception and other stall inputs are ignored, because the pipeline is empty.
  - When stallreq_if=0: redirect_valid=1, redirect_pc=pending_pc, en_pc=1, go RUN next cycle.
  - Stays in DRAIN indefinitely while stallreq_if=1; there is no timeout.
- Fetched-word discard: an in-flight fetch that completes during DRAIN has its word discarded by flush_if_id.
- rst mid-DRAIN returns to RUN and discards pending_pc.
- redirect_valid is never high in two consecutive cycles caused by the same exception.

Decomposition:
- Shared package (core_pkg, alongside define.vh constants):
  - ctrl_state_t enum {RUN, DRAIN}.
  - Stage index constants STG_IF..STG_MEM.
  - EXC_VECTOR / RESET_PC defaults.
- One natural sub-module, stall_decode: purely combinational. Maps stallreq[3:0] to en[4:0]/flush[4:1].
- pipe_ctrl owns the FSM, pending_pc and the exception override.

Test Plan:
- Reset then release with no stalls -> all en=1, flush=0, redirect_valid=0. During rst: flush_*=1, redirect_pc=32'hBFC00000.
- stallreq_ex=1 for 3 cycles with stallreq_id=1 -> en_pc/en_if_id/en_id_ex=0, flush_ex_mem=1, en_mem_wb=1 each cycle. Normal flow resumes the cycle after the drop.
- mem_except_valid=1 with stallreq_mem=1 and stallreq_if=0 -> redirect_valid=1, redirect_pc=32'hBFC00380, flush if_id/id_ex/ex_mem, en_mem_wb=1, state stays RUN.
- mem_eret=1, cp0_epc=32'h8000_1234, stallreq_if=1 for 4 cycles -> DRAIN for 4 cycles (busy_drain=1, en_pc=0, all flush=1). Then one cycle with redirect_valid=1, redirect_pc=32'h8000_1234, then RUN.
- mem_except_valid and mem_eret both 1, cp0_epc=32'h1 -> redirect_pc=32'hBFC00380.
- rst asserted on the 2nd DRAIN cycle -> next cycle RUN, busy_drain=0. No redirect to the old pending_pc after rst release.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer: state encoding, stage
// indices and default redirect addresses.
package pipe_ctrl_pkg;

  // Sequencer state encoding (kept as plain constants for legacy tools).
  typedef logic [0:0] ctrl_state_t;
  localparam ctrl_state_t ST_RUN   = 1'b0;
  localparam ctrl_state_t ST_DRAIN = 1'b1;

  // Stage indices used for stall requests; deeper stages have larger indices.
  localparam int unsigned STG_IF  = 0;
  localparam int unsigned STG_ID  = 1;
  localparam int unsigned STG_EX  = 2;
  localparam int unsigned STG_MEM = 3;

  localparam int unsigned NUM_STG = 4;
  // Pipeline registers: 0=pc, 1=if_id, 2=id_ex, 3=ex_mem, 4=mem_wb.
  localparam int unsigned NUM_REG = 5;

  localparam int unsigned ADDR_W = 32;

  localparam logic [ADDR_W-1:0] EXC_VECTOR_DEF = 32'hBFC0_0380;
  localparam logic [ADDR_W-1:0] RESET_PC_DEF   = 32'hBFC0_0000;

endpackage

// File: rtl/pipe_ctrl_stall_decode.sv
// Combinational stall decoder: maps per-stage stall requests to pipeline
// register enables and bubble inserts.
//   stallreq[3:0] : stall request per stage (IF=0 .. MEM=3)
//   en[4:0]       : register enables (pc, if_id, id_ex, ex_mem, mem_wb)
//   flush[4:1]    : bubble inserts (if_id .. mem_wb)
module pipe_ctrl_stall_decode
  import pipe_ctrl_pkg::*;
(
  input  logic [NUM_STG-1:0] stallreq,
  output logic [NUM_REG-1:0] en,
  output logic [NUM_REG-1:1] flush
);

  logic       any_stall;
  logic [2:0] deepest;

  // Deepest stalled stage holds itself and everything before it; the
  // register right after it receives a bubble.
  always_comb begin
    any_stall = |stallreq;
    deepest   = 3'd0;
    if (stallreq[STG_MEM])     deepest = 3'(STG_MEM);
    else if (stallreq[STG_EX]) deepest = 3'(STG_EX);
    else if (stallreq[STG_ID]) deepest = 3'(STG_ID);
    else                       deepest = 3'(STG_IF);

    en    = '0;
    flush = '0;
    for (int j = 0; j < NUM_REG; j++) begin
      en[j] = !any_stall || (3'(j) > deepest);
    end
    for (int j = 1; j < NUM_REG; j++) begin
      flush[j] = any_stall && (3'(j) == (deepest + 3'd1));
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline sequencer for the 5-stage core. Generates per-register
// enables/flushes from stage stall requests and handles exception/ERET
// redirects, deferring the redirect while an instruction fetch drains.
//   clk, rst                 : clock, synchronous active-high reset
//   stallreq_if/id/ex/mem    : per-stage stall requests
//   mem_except_valid         : MEM-stage exception (not ERET)
//   mem_eret                 : MEM-stage ERET
//   cp0_epc                  : current EPC
//   en_*                     : pipeline register enables
//   flush_*                  : bubble inserts (flush wins over enable)
//   redirect_valid/pc        : load pc from redirect_pc this cycle
//   busy_drain               : high while waiting for a fetch to drain
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF,
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic        mem_except_valid,
  input  logic        mem_eret,
  input  logic [31:0] cp0_epc,
  output logic        en_pc,
  output logic        en_if_id,
  output logic        en_id_ex,
  output logic        en_ex_mem,
  output logic        en_mem_wb,
  output logic        flush_if_id,
  output logic        flush_id_ex,
  output logic        flush_ex_mem,
  output logic        flush_mem_wb,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        busy_drain
);

  ctrl_state_t         state, state_nx;
  logic [ADDR_W-1:0]   pending_pc, pending_pc_nx;
  logic [NUM_STG-1:0]  stallreq;
  logic [NUM_REG-1:0]  dec_en;
  logic [NUM_REG-1:1]  dec_flush;
  logic                exc_any;
  logic [ADDR_W-1:0]   exc_target;

  assign stallreq = {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if};

  pipe_ctrl_stall_decode u_stall_decode (
    .stallreq (stallreq),
    .en       (dec_en),
    .flush    (dec_flush)
  );

  // A real exception outranks ERET when both are reported.
  assign exc_any    = mem_except_valid || mem_eret;
  assign exc_target = mem_except_valid ? EXC_VECTOR : cp0_epc;

  // State and pending redirect target.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_RUN;
      pending_pc <= '0;
    end else begin
      state      <= state_nx;
      pending_pc <= pending_pc_nx;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_nx       = state;
    pending_pc_nx  = pending_pc;
    en_pc          = dec_en[0];
    en_if_id       = dec_en[1];
    en_id_ex       = dec_en[2];
    en_ex_mem      = dec_en[3];
    en_mem_wb      = dec_en[4];
    flush_if_id    = dec_flush[1];
    flush_id_ex    = dec_flush[2];
    flush_ex_mem   = dec_flush[3];
    flush_mem_wb   = dec_flush[4];
    redirect_valid = 1'b0;
    redirect_pc    = exc_target;
    busy_drain     = 1'b0;

    if (rst) begin
      en_pc        = 1'b0;
      en_if_id     = 1'b0;
      en_id_ex     = 1'b0;
      en_ex_mem    = 1'b0;
      en_mem_wb    = 1'b0;
      flush_if_id  = 1'b1;
      flush_id_ex  = 1'b1;
      flush_ex_mem = 1'b1;
      flush_mem_wb = 1'b1;
      redirect_pc  = RESET_PC;
    end else begin
      case (state)
        ST_RUN: begin
          if (exc_any) begin
            // Squash younger instructions; let the faulting one commit.
            en_if_id     = 1'b0;
            en_id_ex     = 1'b0;
            en_ex_mem    = 1'b0;
            en_mem_wb    = 1'b1;
            flush_if_id  = 1'b1;
            flush_id_ex  = 1'b1;
            flush_ex_mem = 1'b1;
            flush_mem_wb = 1'b0;
            if (stallreq_if) begin
              // Fetch in flight: park the target until the bus is free.
              en_pc         = 1'b0;
              pending_pc_nx = exc_target;
              state_nx      = ST_DRAIN;
            end else begin
              en_pc          = 1'b1;
              redirect_valid = 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          // Pipeline is empty; the late fetch word is dropped by flush_if_id.
          busy_drain     = 1'b1;
          en_if_id       = 1'b0;
          en_id_ex       = 1'b0;
          en_ex_mem      = 1'b0;
          en_mem_wb      = 1'b0;
          flush_if_id    = 1'b1;
          flush_id_ex    = 1'b1;
          flush_ex_mem   = 1'b1;
          flush_mem_wb   = 1'b1;
          redirect_pc    = pending_pc;
          en_pc          = !stallreq_if;
          redirect_valid = !stallreq_if;
          if (!stallreq_if) begin
            state_nx = ST_RUN;
          end
        end
        default: begin
          state_nx = ST_RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
  logic        mem_except_valid, mem_eret;
  logic [31:0] cp0_epc;
  logic        en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb;
  logic        flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb;
  logic        redirect_valid, busy_drain;
  logic [31:0] redirect_pc;

  int checks   = 0;
  int failures = 0;

  pipe_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .stallreq_if      (stallreq_if),
    .stallreq_id      (stallreq_id),
    .stallreq_ex      (stallreq_ex),
    .stallreq_mem     (stallreq_mem),
    .mem_except_valid (mem_except_valid),
    .mem_eret         (mem_eret),
    .cp0_epc          (cp0_epc),
    .en_pc            (en_pc),
    .en_if_id         (en_if_id),
    .en_id_ex         (en_id_ex),
    .en_ex_mem        (en_ex_mem),
    .en_mem_wb        (en_mem_wb),
    .flush_if_id      (flush_if_id),
    .flush_id_ex      (flush_id_ex),
    .flush_ex_mem     (flush_ex_mem),
    .flush_mem_wb     (flush_mem_wb),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .busy_drain       (busy_drain)
  );

  always #5 clk = ~clk;

  // {en pc,if_id,id_ex,ex_mem,mem_wb, flush if_id,id_ex,ex_mem,mem_wb, redirect_valid, busy_drain}
  logic [10:0] ctl;
  assign ctl = {en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb,
                flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb,
                redirect_valid, busy_drain};

  localparam logic [10:0] M_ALL   = 11'b1_1111_1111_11;
  // Exception in RUN: enables of flushed registers are don't-care.
  localparam logic [10:0] M_EXC   = 11'b1_0001_1111_11;
  // DRAIN: only en_pc among the enables matters.
  localparam logic [10:0] M_DRAIN = 11'b1_0000_1111_11;

  localparam logic [10:0] C_RESET  = 11'b0_0000_1111_00;
  localparam logic [10:0] C_NORMAL = 11'b1_1111_0000_00;
  localparam logic [10:0] C_EXC_RD = 11'b1_0001_1110_10;
  localparam logic [10:0] C_EXC_WT = 11'b0_0001_1110_00;
  localparam logic [10:0] C_DRAIN  = 11'b0_0000_1111_01;
  localparam logic [10:0] C_DR_OUT = 11'b1_0000_1111_11;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_ctl(input string tag, input logic [10:0] exp, input logic [10:0] mask);
    check(tag, 32'(ctl & mask), 32'(exp & mask));
  endtask

  // Apply inputs after the falling edge and let the combinational outputs settle.
  task automatic apply(input logic r, input logic sif, input logic sid, input logic sex,
                       input logic smem, input logic exc, input logic eret,
                       input logic [31:0] epc);
    @(negedge clk);
    rst = r; stallreq_if = sif; stallreq_id = sid; stallreq_ex = sex;
    stallreq_mem = smem; mem_except_valid = exc; mem_eret = eret; cp0_epc = epc;
    #1;
  endtask

  initial begin
    rst = 1'b1; stallreq_if = 0; stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 0;
    mem_except_valid = 0; mem_eret = 0; cp0_epc = '0;

    // Reset behaviour
    apply(1, 0, 0, 0, 0, 0, 0, 32'h0);
    check_ctl("rst_ctl", C_RESET, M_ALL);
    check("rst_pc", redirect_pc, 32'hBFC0_0000);
    apply(1, 1, 1, 1, 1, 1, 1, 32'h0);
    check_ctl("rst_ctl_inputs", C_RESET, M_ALL);

    apply(0, 0, 0, 0, 0, 0, 0, 32'h0);
    check_ctl("run_nostall", C_NORMAL, M_ALL);

    // EX+ID stall for 3 cycles: hold pc..id_ex, bubble ex_mem
    for (int i = 0; i < 3; i++) begin
      apply(0, 0, 1, 1, 0, 0, 0, 32'h0);
      check_ctl("stall_ex", 11'b0_0011_0010_00, 11'b1_1101_1111_11);
    end
    apply(0, 0, 0, 0, 0, 0, 0, 32'h0);
    check_ctl("stall_ex_release", C_NORMAL, M_ALL);

    // Single-stage stalls
    apply(0, 1, 0, 0, 0, 0, 0, 32'h0);
    check_ctl("stall_if", 11'b0_1111_1000_00, 11'b1_0111_1111_11);
    apply(0, 0, 1, 0, 0, 0, 0, 32'h0);
    check_ctl("stall_id", 11'b0_0111_0100_00, 11'b1_1011_1111_11);
    apply(0, 1, 1, 1, 1, 0, 0, 32'h0);
    check_ctl("stall_mem", 11'b0_0001_0001_00, 11'b1_1110_1111_11);

    // Exception outranks MEM stall, immediate redirect
    apply(0, 0, 0, 0, 1, 1, 0, 32'h0);
    check_ctl("exc_ctl", C_EXC_RD, M_EXC);
    check("exc_pc", redirect_pc, 32'hBFC0_0380);
    apply(0, 0, 0, 0, 0, 0, 0, 32'h0);
    check_ctl("exc_stays_run", C_NORMAL, M_ALL);

    // ERET with fetch in flight: wait, drain 4 cycles, then redirect to EPC
    apply(0, 1, 0, 0, 0, 0, 1, 32'h8000_1234);
    check_ctl("eret_wait", C_EXC_WT, M_EXC);
    for (int i = 0; i < 4; i++) begin
      // Exception input in DRAIN must be ignored.
      apply(0, 1, 1, 0, 0, (i == 1), 0, 32'h0);
      check_ctl("drain_ctl", C_DRAIN, M_DRAIN);
    end
    apply(0, 0, 0, 1, 0, 0, 0, 32'h0);
    check_ctl("drain_exit", C_DR_OUT, M_DRAIN);
    check("drain_pc", redirect_pc, 32'h8000_1234);
    apply(0, 0, 0, 0, 0, 0, 0, 32'h0);
    check_ctl("drain_back_run", C_NORMAL, M_ALL);

    // Exception beats ERET
    apply(0, 0, 0, 0, 0, 1, 1, 32'h0000_0001);
    check_ctl("both_ctl", C_EXC_RD, M_EXC);
    check("both_pc", redirect_pc, 32'hBFC0_0380);

    // Reset on the 2nd DRAIN cycle discards the pending target
    apply(0, 1, 0, 0, 0, 0, 1, 32'h1234_5678);
    check_ctl("rd_wait", C_EXC_WT, M_EXC);
    apply(0, 1, 0, 0, 0, 0, 0, 32'h0);
    check_ctl("rd_drain1", C_DRAIN, M_DRAIN);
    apply(1, 1, 0, 0, 0, 0, 0, 32'h0);
    check_ctl("rd_rst", C_RESET, M_ALL);
    check("rd_rst_pc", redirect_pc, 32'hBFC0_0000);
    apply(0, 0, 0, 0, 0, 0, 0, 32'h0);
    check_ctl("rd_after_rst", C_NORMAL, M_ALL);
    apply(0, 0, 0, 0, 0, 0, 0, 32'h0);
    check_ctl("rd_no_redirect", C_NORMAL, M_ALL);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
